// File: rtl/aes_host_ctrl.sv
// ---------------------------------------------------------------------------
// aes_host_ctrl
//
// Host-side initiator for a multicycle, static-key AES core. A command byte
// and a 16-byte block arrive over a byte-wide valid/ready stream. The block
// is then handed to the core with a single-cycle load pulse. The controller
// waits for the core's busy window to close, captures the 128-bit result and
// streams it back as 16 bytes, most significant byte first. A registered
// scope trigger brackets the core activity for power capture.
//
// Optional feature (compile-time macro AES_HOST_STATUS_EN):
//   defined   - one status byte precedes the result: 8'h4B ('K') when the core
//               completed, 8'h54 ('T') when the core never started (timeout).
//               A timeout emits only the status byte.
//   undefined - no status byte; a timeout returns silently to idle.
//
// Ports:
//   clk          clock
//   rst_n        synchronous, active-low reset
//   rx_data_i    inbound byte
//   rx_valid_i   inbound byte valid
//   rx_ready_o   inbound byte accepted (high in S_IDLE and S_RX only)
//   tx_data_o    outbound byte, stable until accepted
//   tx_valid_o   outbound byte valid
//   tx_ready_i   sink accepts outbound byte
//   aes_load_o   one-cycle load pulse to the core
//   aes_dec_o    decrypt select, held until the next command
//   aes_data_o   block to the core, byte 0 in [127:120]
//   aes_data_i   result from the core
//   aes_busy_i   core busy
//   trigger_o    scope trigger, high from the load cycle through result capture
//   busy_o       high whenever the controller is not idle
//
// state        | meaning
// -------------+------------------------------------------------------------
// S_IDLE       | waiting for a command byte; other bytes are dropped
// S_RX         | collecting the 16 block bytes
// S_LOAD       | one-cycle load pulse to the core
// S_WAIT_START | waiting for the core to raise busy, bounded by START_TIMEOUT
// S_WAIT_DONE  | waiting for the core to drop busy, then capture the result
// S_STATUS     | emitting the status byte (AES_HOST_STATUS_EN only)
// S_TX         | emitting the 16 result bytes
// ---------------------------------------------------------------------------
module aes_host_ctrl #(
  parameter int unsigned START_TIMEOUT = 8,
  parameter logic [7:0]  CMD_ENC       = 8'h45,
  parameter logic [7:0]  CMD_DEC       = 8'h44
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data_i,
  input  logic         rx_valid_i,
  output logic         rx_ready_o,
  output logic [7:0]   tx_data_o,
  output logic         tx_valid_o,
  input  logic         tx_ready_i,
  output logic         aes_load_o,
  output logic         aes_dec_o,
  output logic [127:0] aes_data_o,
  input  logic [127:0] aes_data_i,
  input  logic         aes_busy_i,
  output logic         trigger_o,
  output logic         busy_o
);

  // The start timer counts down from START_TIMEOUT-1; reaching zero with the
  // core still idle means START_TIMEOUT cycles have elapsed since the load.
  localparam logic [7:0] TMO_LOAD = 8'(START_TIMEOUT - 1);

`ifdef AES_HOST_STATUS_EN
  localparam logic [7:0] STATUS_OK  = 8'h4B;
  localparam logic [7:0] STATUS_TMO = 8'h54;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE,
`ifdef AES_HOST_STATUS_EN
    S_STATUS,
`endif
    S_TX
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [3:0]     byte_cnt;
  logic [7:0]     tmo_cnt;
  logic [127:0]   result;
  logic           rx_fire;
  logic           tx_fire;
  logic           is_cmd;
`ifdef AES_HOST_STATUS_EN
  logic           status_ok;
`endif

  assign is_cmd  = (rx_data_i == CMD_ENC) || (rx_data_i == CMD_DEC);
  assign rx_fire = rx_valid_i && rx_ready_o;
  assign tx_fire = tx_valid_o && tx_ready_i;

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    aes_load_o = 1'b0;
    busy_o     = 1'b1;

    case (state)
      S_IDLE: begin
        busy_o     = 1'b0;
        rx_ready_o = 1'b1;
        if (rx_fire && is_cmd) begin
          state_nxt = S_RX;
        end
      end

      S_RX: begin
        rx_ready_o = 1'b1;
        if (rx_fire && (byte_cnt == 4'd15)) begin
          state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        aes_load_o = 1'b1;
        state_nxt  = S_WAIT_START;
      end

      S_WAIT_START: begin
        if (aes_busy_i) begin
          state_nxt = S_WAIT_DONE;
        end else if (tmo_cnt == 8'd0) begin
`ifdef AES_HOST_STATUS_EN
          state_nxt = S_STATUS;
`else
          state_nxt = S_IDLE;
`endif
        end
      end

      S_WAIT_DONE: begin
        if (!aes_busy_i) begin
`ifdef AES_HOST_STATUS_EN
          state_nxt = S_STATUS;
`else
          state_nxt = S_TX;
`endif
        end
      end

`ifdef AES_HOST_STATUS_EN
      S_STATUS: begin
        tx_valid_o = 1'b1;
        tx_data_o  = status_ok ? STATUS_OK : STATUS_TMO;
        if (tx_ready_i) begin
          state_nxt = status_ok ? S_TX : S_IDLE;
        end
      end
`endif

      S_TX: begin
        tx_valid_o = 1'b1;
        tx_data_o  = result[127:120];
        if (tx_ready_i && (byte_cnt == 4'd15)) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register and datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      byte_cnt   <= 4'd0;
      tmo_cnt    <= 8'd0;
      aes_data_o <= 128'd0;
      aes_dec_o  <= 1'b0;
      result     <= 128'd0;
      trigger_o  <= 1'b0;
`ifdef AES_HOST_STATUS_EN
      status_ok  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;

      case (state)
        S_IDLE: begin
          if (rx_fire && is_cmd) begin
            aes_dec_o <= (rx_data_i == CMD_DEC);
            byte_cnt  <= 4'd0;
          end
        end

        S_RX: begin
          if (rx_fire) begin
            aes_data_o <= {aes_data_o[119:0], rx_data_i};
            byte_cnt   <= byte_cnt + 4'd1;
            // Raised on the edge into S_LOAD so the trigger is already high
            // in the load cycle itself.
            if (byte_cnt == 4'd15) begin
              trigger_o <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          tmo_cnt <= TMO_LOAD;
        end

        S_WAIT_START: begin
          if (!aes_busy_i) begin
            if (tmo_cnt == 8'd0) begin
              trigger_o <= 1'b0;
`ifdef AES_HOST_STATUS_EN
              status_ok <= 1'b0;
`endif
            end else begin
              tmo_cnt <= tmo_cnt - 8'd1;
            end
          end
        end

        S_WAIT_DONE: begin
          if (!aes_busy_i) begin
            result    <= aes_data_i;
            trigger_o <= 1'b0;
            byte_cnt  <= 4'd0;
`ifdef AES_HOST_STATUS_EN
            status_ok <= 1'b1;
`endif
          end
        end

        S_TX: begin
          // The result register doubles as the output shifter; the head byte
          // is always [127:120].
          if (tx_fire) begin
            result   <= {result[119:0], 8'h00};
            byte_cnt <= byte_cnt + 4'd1;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_host_ctrl
//
// Directed bench for aes_host_ctrl with a small behavioural AES core model
// (busy one cycle after load for 44 cycles, result = bitwise inverse of the
// loaded block). Expected tx bytes, loads and trigger widths are queued when
// stimulus is issued and popped by independent monitors.
// ---------------------------------------------------------------------------
module tb_aes_host_ctrl;

  localparam int START_TIMEOUT = 8;
  localparam int CORE_BUSY     = 44;
  localparam logic [7:0] CMD_ENC = 8'h45;
  localparam logic [7:0] CMD_DEC = 8'h44;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         aes_load;
  logic         aes_dec;
  logic [127:0] aes_data_to_core;
  logic [127:0] core_result = '0;
  logic         core_busy = 1'b0;
  logic         trigger;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]   exp_q[$];
  logic [128:0] load_q[$];
  int           trig_q[$];

  bit   core_en = 1'b1;
  int   core_cnt = 0;
  int   tx_acc = 0;
  int   trig_run = 0;
  bit   load_prev = 1'b0;
  bit   stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  always #5 clk = ~clk;

  aes_host_ctrl #(
    .START_TIMEOUT(START_TIMEOUT),
    .CMD_ENC(CMD_ENC),
    .CMD_DEC(CMD_DEC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data_i(rx_data),
    .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready),
    .tx_data_o(tx_data),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .aes_load_o(aes_load),
    .aes_dec_o(aes_dec),
    .aes_data_o(aes_data_to_core),
    .aes_data_i(core_result),
    .aes_busy_i(core_busy),
    .trigger_o(trigger),
    .busy_o(busy)
  );

  // Core model
  always @(posedge clk) begin
    if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) core_busy <= 1'b0;
    end else if (aes_load && core_en) begin
      core_busy   <= 1'b1;
      core_cnt    <= CORE_BUSY;
      core_result <= ~aes_data_to_core;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // tx monitor / scoreboard
  always @(negedge clk) begin
    if (stall_prev) begin
      chk("tx_hold_valid", 128'(tx_valid), 128'd1);
      if (tx_valid) chk("tx_hold_data", 128'(tx_data), 128'(stall_data));
    end
    stall_prev = 1'b0;
    if (tx_valid) begin
      if (tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got %h expected none", tx_data);
        end else begin
          chk("tx_byte", 128'(tx_data), 128'(exp_q.pop_front()));
        end
        tx_acc++;
      end else begin
        stall_prev = 1'b1;
        stall_data = tx_data;
      end
    end
  end

  // load and trigger monitor
  always @(negedge clk) begin
    logic [128:0] e;
    if (load_prev) chk("load_one_cycle", 128'(aes_load), 128'd0);
    load_prev = aes_load;
    if (aes_load) begin
      if (load_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL load_unexpected: got load with data %h expected none", aes_data_to_core);
      end else begin
        e = load_q.pop_front();
        chk("load_dec", 128'(aes_dec), 128'(e[128]));
        chk("load_data", aes_data_to_core, e[127:0]);
      end
      chk("trigger_at_load", 128'(trigger), 128'd1);
    end
    if (trigger) begin
      trig_run++;
    end else if (trig_run > 0) begin
      if (trig_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL trigger_unexpected: got width %0d expected none", trig_run);
      end else begin
        int te;
        te = trig_q.pop_front();
        if (te >= 0) chk("trigger_width", 128'(trig_run), 128'(te));
      end
      trig_run = 0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_ready && n < 1000);
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  // Queues the expected response, then sends command and block.
  task automatic issue(input logic [7:0] cmd, input logic [127:0] blk, input bit ok,
                       input int gap_max, input int trig_exp, input bit expect_tx);
    load_q.push_back({cmd == CMD_DEC, blk});
    trig_q.push_back(trig_exp);
    if (expect_tx) begin
`ifdef AES_HOST_STATUS_EN
      exp_q.push_back(ok ? 8'h4B : 8'h54);
`endif
      if (ok) begin
        for (int i = 0; i < 16; i++) exp_q.push_back(~blk[127-8*i -: 8]);
      end
    end
    send_byte(cmd, (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
    for (int i = 0; i < 16; i++) begin
      send_byte(blk[127-8*i -: 8], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d expected 0 0", busy, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_trigger"}, 128'(trigger), 128'd0);
    chk({tag, "_load"}, 128'(aes_load), 128'd0);
    chk({tag, "_tx_valid"}, 128'(tx_valid), 128'd0);
    chk({tag, "_rx_ready"}, 128'(rx_ready), 128'd1);
    chk({tag, "_dec"}, 128'(aes_dec), 128'd0);
    chk({tag, "_data"}, aes_data_to_core, 128'd0);
  endtask

  initial begin
    logic [127:0] blk_enc;
    logic [127:0] blk_dec;
    logic [127:0] blk_x;
    int n;

    blk_enc = 128'h00112233445566778899aabbccddeeff;
    blk_dec = {16{8'hA5}};
    blk_x   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Encrypt round trip
    issue(CMD_ENC, blk_enc, 1'b1, 0, 46, 1'b1);
    wait_idle();

    // Decrypt select
    issue(CMD_DEC, blk_dec, 1'b1, 0, 46, 1'b1);
    wait_idle();

    // Junk bytes before a command are dropped
    send_byte(8'h00, 0);
    send_byte(8'h13, 1);
    issue(CMD_ENC, blk_x, 1'b1, 0, 46, 1'b1);
    wait_idle();

    // rx gaps and a 5-cycle tx stall mid-stream
    n = tx_acc;
    issue(CMD_DEC, ~blk_x, 1'b1, 3, 46, 1'b1);
    begin
      int k;
      k = 0;
      while (tx_acc < n + 5 && k < 500) begin
        @(negedge clk);
        k++;
      end
      if (tx_acc < n + 5) begin
        checks++;
        errors++;
        $display("FAIL tx_progress: got %0d expected %0d", tx_acc - n, 5);
      end
    end
    @(posedge clk);
    #1 tx_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_idle();

    // Timeout: core never starts
    core_en = 1'b0;
    issue(CMD_ENC, blk_enc, 1'b0, 0, START_TIMEOUT + 1, 1'b1);
    wait_idle();
    core_en = 1'b1;
    issue(CMD_ENC, blk_dec, 1'b1, 1, 46, 1'b1);
    wait_idle();

    // Reset during S_WAIT_DONE
    issue(CMD_DEC, blk_x, 1'b1, 0, -1, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    n = 0;
    while ((core_cnt != 0 || core_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    issue(CMD_ENC, blk_x, 1'b1, 0, 46, 1'b1);
    wait_idle();

    repeat (5) @(posedge clk);
    chk("loads_pending", 128'(load_q.size()), 128'd0);
    chk("triggers_pending", 128'(trig_q.size()), 128'd0);
    chk("tx_pending", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
